// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one memory slave port among CNT masters and routes responses in order.
// Define MEM_RR_ARB_CREDIT_EN to add per-master outstanding-request limits (MAX_OUTSTANDING).
module mem_rr_arbiter #(
    parameter int unsigned CNT             = 2,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned REQ_W           = 32,
    parameter int unsigned RESP_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CNT-1:0]                 master_req_valid,
    output logic [CNT-1:0]                 master_req_ready,
    input  logic [CNT-1:0][REQ_W-1:0]      master_req_data,
    output logic [CNT-1:0]                 master_resp_valid,
    input  logic [CNT-1:0]                 master_resp_ready,
    output logic [CNT-1:0][RESP_W-1:0]     master_resp_data,
    output logic                           slave_req_valid,
    input  logic                           slave_req_ready,
    output logic [REQ_W-1:0]               slave_req_data,
    input  logic                           slave_resp_valid,
    output logic                           slave_resp_ready,
    input  logic [RESP_W-1:0]              slave_resp_data
);

    localparam int unsigned IDXW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int unsigned PTRW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNTW = $clog2(QUEUE_DEPTH) + 1;

    if (CNT < 1) begin : gen_bad_cnt
        $error("mem_rr_arbiter: CNT must be at least 1");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("mem_rr_arbiter: QUEUE_DEPTH must be a power of two, at least 2");
    end
    if (MAX_OUTSTANDING < 1) begin : gen_bad_max
        $error("mem_rr_arbiter: MAX_OUTSTANDING must be at least 1");
    end

    logic [IDXW-1:0] prio_q;
    logic            lock_q;
    logic [IDXW-1:0] lock_idx_q;

    logic [IDXW-1:0] fifo_q [QUEUE_DEPTH];
    logic [PTRW-1:0] wr_ptr_q;
    logic [PTRW-1:0] rd_ptr_q;
    logic [CNTW-1:0] count_q;

    logic [CNT-1:0]  eligible;
    logic            any_eligible;
    logic [IDXW-1:0] sel_scan;
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_hs;
    logic            resp_hs;

    // ---------------------------------------------------------------------
    // Eligibility
    // ---------------------------------------------------------------------
`ifdef MEM_RR_ARB_CREDIT_EN
    localparam int unsigned CREDW = $clog2(MAX_OUTSTANDING + 1);

    logic [CREDW-1:0] credit_q [CNT];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < CNT; i++) begin
            eligible[i] = master_req_valid[i] && (credit_q[i] < CREDW'(MAX_OUTSTANDING));
        end
    end

    // Same-cycle increment and decrement of one master cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CNT; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CNT; i++) begin
                case ({req_hs && sel == IDXW'(i), resp_hs && head == IDXW'(i)})
                    2'b10:   credit_q[i] <= credit_q[i] + CREDW'(1);
                    2'b01:   credit_q[i] <= credit_q[i] - CREDW'(1);
                    default: credit_q[i] <= credit_q[i];
                endcase
            end
        end
    end
`else
    assign eligible = master_req_valid;
`endif

    assign any_eligible = |eligible;

    // ---------------------------------------------------------------------
    // Round-robin selection starting at prio_q; explicit wrap so any CNT works.
    // ---------------------------------------------------------------------
    always_comb begin
        logic [IDXW-1:0] idx;
        logic            found;
        idx      = prio_q;
        found    = 1'b0;
        sel_scan = prio_q;
        for (int k = 0; k < CNT; k++) begin
            if (!found && eligible[idx]) begin
                sel_scan = idx;
                found    = 1'b1;
            end
            idx = (idx == IDXW'(CNT - 1)) ? '0 : idx + IDXW'(1);
        end
    end

    assign sel = lock_q ? lock_idx_q : sel_scan;

    // ---------------------------------------------------------------------
    // Request path
    // ---------------------------------------------------------------------
    assign fifo_full       = (count_q == CNTW'(QUEUE_DEPTH));
    assign fifo_empty      = (count_q == '0);
    assign slave_req_valid = rst && any_eligible && !fifo_full;
    assign slave_req_data  = master_req_data[sel];
    assign req_hs          = slave_req_valid && slave_req_ready;

    always_comb begin
        master_req_ready = '0;
        for (int i = 0; i < CNT; i++) begin
            master_req_ready[i] = req_hs && (sel == IDXW'(i));
        end
    end

    // ---------------------------------------------------------------------
    // Response routing from the FIFO head
    // ---------------------------------------------------------------------
    assign head             = fifo_q[rd_ptr_q];
    assign slave_resp_ready = rst && !fifo_empty && master_resp_ready[head];
    assign resp_hs          = slave_resp_valid && slave_resp_ready;

    always_comb begin
        master_resp_valid = '0;
        for (int i = 0; i < CNT; i++) begin
            master_resp_valid[i] = slave_resp_valid && !fifo_empty && (head == IDXW'(i));
            master_resp_data[i]  = slave_resp_data;
        end
    end

    // ---------------------------------------------------------------------
    // Arbitration state: priority pointer and stall lock
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (req_hs) begin
                prio_q <= (sel == IDXW'(CNT - 1)) ? '0 : sel + IDXW'(1);
                lock_q <= 1'b0;
            end else if (slave_req_valid) begin
                // Hold the grant until the slave takes it.
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Routing FIFO of master indices
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (req_hs) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= wr_ptr_q + PTRW'(1);
            end
            if (resp_hs) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            case ({req_hs, resp_hs})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with CNT=3, QUEUE_DEPTH=4; credit steps run when
// MEM_RR_ARB_CREDIT_EN is defined.
module tb_mem_rr_arbiter;

    localparam int unsigned CNT = 3;
    localparam int unsigned W   = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CNT-1:0]         m_req_valid;
    logic [CNT-1:0]         m_req_ready;
    logic [CNT-1:0][W-1:0]  m_req_data;
    logic [CNT-1:0]         m_resp_valid;
    logic [CNT-1:0]         m_resp_ready;
    logic [CNT-1:0][W-1:0]  m_resp_data;
    logic                   s_req_valid;
    logic                   s_req_ready;
    logic [W-1:0]           s_req_data;
    logic                   s_resp_valid;
    logic                   s_resp_ready;
    logic [W-1:0]           s_resp_data;

    int total = 0;
    int bad   = 0;

    mem_rr_arbiter #(
        .CNT             (CNT),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2),
        .REQ_W           (W),
        .RESP_W          (W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .master_req_valid  (m_req_valid),
        .master_req_ready  (m_req_ready),
        .master_req_data   (m_req_data),
        .master_resp_valid (m_resp_valid),
        .master_resp_ready (m_resp_ready),
        .master_resp_data  (m_resp_data),
        .slave_req_valid   (s_req_valid),
        .slave_req_ready   (s_req_ready),
        .slave_req_data    (s_req_data),
        .slave_resp_valid  (s_resp_valid),
        .slave_resp_ready  (s_resp_ready),
        .slave_resp_data   (s_resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        m_req_valid  = 3'b111;
        m_req_data   = {8'hA2, 8'hA1, 8'hA0};
        m_resp_ready = 3'b111;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b1;
        s_resp_data  = 8'h00;
        #1;
        check("rst_sreq_valid", 32'(s_req_valid), 32'd0);
        check("rst_mreq_ready", 32'(m_req_ready), 32'd0);
        check("rst_sresp_ready", 32'(s_resp_ready), 32'd0);
        check("rst_mresp_valid", 32'(m_resp_valid), 32'd0);

        // Round robin 0,1,2,0 then FIFO full
        tick();
        rst          = 1'b1;
        s_resp_valid = 1'b0;
        #1;
        check("rr0_ready", 32'(m_req_ready), 32'b001);
        check("rr0_data", 32'(s_req_data), 32'hA0);
        tick(); #1;
        check("rr1_ready", 32'(m_req_ready), 32'b010);
        check("rr1_data", 32'(s_req_data), 32'hA1);
        tick(); #1;
        check("rr2_ready", 32'(m_req_ready), 32'b100);
        tick(); #1;
        check("rr3_wrap_ready", 32'(m_req_ready), 32'b001);
        tick(); #1;
        check("full_sreq_valid", 32'(s_req_valid), 32'd0);

        // Pop one: same-cycle push still blocked
        s_resp_valid = 1'b1;
        s_resp_data  = 8'h55;
        #1;
        check("pop_mresp_valid", 32'(m_resp_valid), 32'b001);
        check("pop_sresp_ready", 32'(s_resp_ready), 32'd1);
        check("pop_mresp_data0", 32'(m_resp_data[0]), 32'h55);
        check("pop_same_cycle_blocked", 32'(s_req_valid), 32'd0);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("after_pop_ready", 32'(m_req_ready), 32'b010);
        tick();

        // FIFO now holds 1,2,0,1; master 1 stalls the head
        m_req_valid  = 3'b000;
        m_resp_ready = 3'b101;
        s_resp_valid = 1'b1;
        #1;
        check("route_hold_valid", 32'(m_resp_valid), 32'b010);
        check("route_hold_sready", 32'(s_resp_ready), 32'd0);
        tick(); #1;
        check("route_hold2_sready", 32'(s_resp_ready), 32'd0);
        m_resp_ready = 3'b111;
        #1;
        check("route_r1_sready", 32'(s_resp_ready), 32'd1);
        tick(); #1;
        check("route_r2_valid", 32'(m_resp_valid), 32'b100);
        tick(); #1;
        check("route_r3_valid", 32'(m_resp_valid), 32'b001);
        tick(); #1;
        check("route_r4_valid", 32'(m_resp_valid), 32'b010);
        tick(); #1;
        check("empty_mresp_valid", 32'(m_resp_valid), 32'b000);
        check("empty_sresp_ready", 32'(s_resp_ready), 32'd0);
        s_resp_valid = 1'b0;

        // Stall hold: prio is 2, master 1 granted, master 0 arrives while locked
        m_req_valid = 3'b010;
        m_req_data  = {8'hB2, 8'hB1, 8'hB0};
        s_req_ready = 1'b0;
        #1;
        check("stall_c1_valid", 32'(s_req_valid), 32'd1);
        check("stall_c1_data", 32'(s_req_data), 32'hB1);
        check("stall_c1_ready", 32'(m_req_ready), 32'b000);
        tick();
        m_req_valid = 3'b011;
        #1;
        check("stall_c2_data", 32'(s_req_data), 32'hB1);
        check("stall_c2_valid", 32'(s_req_valid), 32'd1);
        tick(); #1;
        check("stall_c3_data", 32'(s_req_data), 32'hB1);
        tick();
        s_req_ready = 1'b1;
        #1;
        check("stall_c4_ready", 32'(m_req_ready), 32'b010);
        tick();
        m_req_valid = 3'b001;
        #1;
        check("stall_c5_ready", 32'(m_req_ready), 32'b001);
        check("stall_c5_data", 32'(s_req_data), 32'hB0);
        tick();

        // Third queued entry, then stall and async reset
        m_req_valid = 3'b100;
        #1;
        check("q3_ready", 32'(m_req_ready), 32'b100);
        tick();
        m_req_valid = 3'b010;
        s_req_ready = 1'b0;
        #1;
        check("pre_rst_valid", 32'(s_req_valid), 32'd1);
        tick();
        #1;
        rst          = 1'b0;
        m_req_valid  = 3'b111;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b1;
        #1;
        check("async_sreq_valid", 32'(s_req_valid), 32'd0);
        check("async_mreq_ready", 32'(m_req_ready), 32'd0);
        check("async_sresp_ready", 32'(s_resp_ready), 32'd0);
        check("async_mresp_valid", 32'(m_resp_valid), 32'd0);
        #2;
        rst         = 1'b1;
        m_req_valid = 3'b110;
        #1;
        check("post_rst_grant", 32'(m_req_ready), 32'b010);
        check("post_rst_empty_valid", 32'(m_resp_valid), 32'b000);
        check("post_rst_empty_sready", 32'(s_resp_ready), 32'd0);
        tick();
        m_req_valid = 3'b000;
        s_resp_data = 8'h77;
        #1;
        check("post_rst_route", 32'(m_resp_valid), 32'b010);
        check("post_rst_data1", 32'(m_resp_data[1]), 32'h77);
        tick();
        s_resp_valid = 1'b0;

`ifdef MEM_RR_ARB_CREDIT_EN
        m_req_valid = 3'b001;
        #1;
        check("cred_req1", 32'(m_req_ready), 32'b001);
        tick(); #1;
        check("cred_req2", 32'(m_req_ready), 32'b001);
        tick(); #1;
        check("cred_blocked", 32'(s_req_valid), 32'd0);
        s_resp_valid = 1'b1;
        #1;
        check("cred_pop_sready", 32'(s_resp_ready), 32'd1);
        check("cred_pop_still_blocked", 32'(s_req_valid), 32'd0);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("cred_req3", 32'(m_req_ready), 32'b001);
        tick();
        m_req_valid = 3'b000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
